// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: shared state encoding and default constants for the reset sequencer
package rst_seq_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } rst_seq_state_t;

    localparam int RST_SEQ_N_CH_DEF         = 4;
    localparam int RST_SEQ_SYNC_DEF         = 2;
    localparam int RST_SEQ_HOLD_DEF         = 16;
    localparam int RST_SEQ_STAGGER_DEF      = 8;
    localparam int RST_SEQ_DEBOUNCE_1MS_65M = 65000;

    function automatic int rst_seq_max3(int a, int b, int c);
        return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
    endfunction

endpackage

// File: rtl/rst_seq_debounce.sv
// debounce: synchroniser plus stable-level counter; counter present only with RST_SEQ_DEBOUNCE_EN
module debounce
    import rst_seq_pkg::*;
#(
    parameter int SYNC_STAGES     = RST_SEQ_SYNC_DEF,
    parameter int DEBOUNCE_CYCLES = RST_SEQ_DEBOUNCE_1MS_65M
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic lvl_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_s;

    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_param
        $error("debounce: SYNC_STAGES must be >= 2 and DEBOUNCE_CYCLES >= 1");
    end

    // shift the asynchronous input through the synchroniser chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

`ifdef RST_SEQ_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign cnt_d = (cnt_q == CW'(DEBOUNCE_CYCLES)) ? cnt_q : cnt_q + 1'b1;

    // count consecutive high cycles, saturating; any low cycle restarts the count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       cnt_q <= '0;
        else if (!sync_s) cnt_q <= '0;
        else              cnt_q <= cnt_d;
    end

    // level rises in the cycle after DEBOUNCE_CYCLES highs and drops with the first low
    assign lvl_o = sync_s && (cnt_q == CW'(DEBOUNCE_CYCLES));
`else
    assign lvl_o = sync_s;
`endif

endmodule

// File: rtl/rst_sequencer.sv
// rst_sequencer: waits for PLL lock, holds, then releases reset channels in index order
// (button debounce is enabled by defining RST_SEQ_DEBOUNCE_EN)
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int N_CH            = RST_SEQ_N_CH_DEF,
    parameter int SYNC_STAGES     = RST_SEQ_SYNC_DEF,
    parameter int HOLD_CYCLES     = RST_SEQ_HOLD_DEF,
    parameter int STAGGER_CYCLES  = RST_SEQ_STAGGER_DEF,
    parameter int DEBOUNCE_CYCLES = RST_SEQ_DEBOUNCE_1MS_65M
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            locked_i,
    input  logic            btn_i,
    input  logic            rst_req_i,
    output logic [N_CH-1:0] rst_o,
    output logic            ready_o,
    output logic [1:0]      state_o
);

    localparam int CW  = $clog2(rst_seq_max3(HOLD_CYCLES, STAGGER_CYCLES, DEBOUNCE_CYCLES) + 1);
    localparam int CHW = $clog2(N_CH + 1);

    logic [SYNC_STAGES-1:0] lock_sync_q;
    logic                   locked_s;
    logic                   btn_lvl;
    logic                   abort;
    rst_seq_state_t         state_q;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;
    logic [CHW-1:0]         ch_q;
    logic [N_CH-1:0]        rst_q;
    logic                   ready_q;

    debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .clk  (clk),
        .rst_n(rst_n),
        .d_i  (btn_i),
        .lvl_o(btn_lvl)
    );

    // bring the asynchronous lock indication into the clock domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lock_sync_q <= '0;
        else        lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], locked_i};
    end

    assign locked_s = lock_sync_q[SYNC_STAGES-1];
    assign abort    = !locked_s || btn_lvl || rst_req_i;
    assign cnt_d    = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + 1'b1;

    // sequencer FSM; resets stay a contiguous run of ones at the top, so a left shift releases the next channel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
            ch_q    <= '0;
            rst_q   <= '1;
            ready_q <= 1'b0;
        end else if (abort) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
            ch_q    <= '0;
            rst_q   <= '1;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    state_q <= HOLD;
                    cnt_q   <= '0;
                end
                HOLD: begin
                    if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
                        rst_q   <= rst_q << 1;
                        ch_q    <= CHW'(1);
                        cnt_q   <= '0;
                        state_q <= (N_CH == 1) ? RUN : RELEASE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                RELEASE: begin
                    if (cnt_q == CW'(STAGGER_CYCLES - 1)) begin
                        rst_q   <= rst_q << 1;
                        ch_q    <= ch_q + 1'b1;
                        cnt_q   <= '0;
                        state_q <= (ch_q == CHW'(N_CH - 1)) ? RUN : RELEASE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                RUN:     ready_q <= 1'b1;
                default: state_q <= WAIT_LOCK;
            endcase
        end
    end

    assign rst_o   = rst_q;
    assign ready_o = ready_q;
    assign state_o = state_q;

endmodule

// File: doc/rst_sequencer.md
# rst_sequencer

Parametrised reset and start-up sequencer for the FPGA top level. It replaces the single `safe_start` register and the unused PLL `locked` output. It waits for the clock wizard to lock, holds all domains in reset for a programmable time, then releases N reset channels one after another in a fixed order. Any later loss of lock, a button press or a soft request re-asserts every channel at once and restarts the sequence.

## Interface
Parameters:
- `N_CH`, 4: number of reset output channels (≥1).
- `SYNC_STAGES`, 2: synchroniser depth for `locked_i` and `btn_i` (≥2).
- `HOLD_CYCLES`, 16: cycles of continuous lock required before the first release (≥1).
- `STAGGER_CYCLES`, 8: spacing between consecutive channel releases (≥1).
- `DEBOUNCE_CYCLES`, 65000: cycles of stable pressed button required (1 ms at 65 MHz) (≥1).

Ports:
- `clk`  in  1: system clock (65 MHz pixel clock).
- `rst_n`  in  1: reset. Asynchronous, active-low. One clock; reset is asynchronous and active-low.
- `locked_i`  in  1: PLL lock, asynchronous.
- `btn_i`  in  1: reset button (btnC), asynchronous, active-high.
- `rst_req_i`  in  1: synchronous soft reset request, level.
- `rst_o`  out  N_CH: active-high resets. Bit 0 is released first.
- `ready_o`  out  1: high when all channels are released.
- `state_o`  out  2: current FSM state, for debug.

## Operation
- `locked_i` and `btn_i` each pass through a SYNC_STAGES flop chain. Their outputs are `locked_s` and `btn_s`.
- `btn_lvl` is the debounced button level (see Configuration).
- `abort` = !locked_s | btn_lvl | rst_req_i.

FSM states: WAIT_LOCK=0, HOLD=1, RELEASE=2, RUN=3.
- **WAIT_LOCK:** `rst_o` is all ones. If !abort, go to HOLD with cnt=0.
- **HOLD:** cnt increments. When cnt reaches HOLD_CYCLES-1 and !abort, go to RELEASE. On the same edge, clear `rst_o[0]` and set ch=1, cnt=0.
- **RELEASE:** cnt increments. When cnt reaches STAGGER_CYCLES-1, clear `rst_o[ch]`, increment ch and set cnt=0. After `rst_o[N_CH-1]` clears, go to RUN.
  - If N_CH=1, go directly from HOLD to RUN.
- **RUN:** `ready_o`=1. Stays here until abort.

Abort and ordering rules:
- An abort in any state other than WAIT_LOCK forces `rst_o` to all ones, `ready_o`=0, cnt=0, ch=0 and state WAIT_LOCK, all on the next edge.
- Abort has priority over any release scheduled on the same edge.
- A bit of `rst_o`, once cleared, stays clear until an abort. Bits clear strictly in index order.
- Counter width is $clog2(max(HOLD_CYCLES, STAGGER_CYCLES, DEBOUNCE_CYCLES)+1). Counters saturate and never wrap.

## Timing
- On `rst_n` low, asynchronously: `rst_o`=all ones, `ready_o`=0, `state_o`=0, counters=0, all synchroniser flops=0.
- Let cycle 0 be the first cycle in which `locked_s`=1 with no abort. Then:
  - state is HOLD from cycle 1;
  - `rst_o[k]` falls at cycle 1+HOLD_CYCLES+k·STAGGER_CYCLES;
  - `ready_o` rises at cycle 2+HOLD_CYCLES+(N_CH-1)·STAGGER_CYCLES.
- An asynchronous `locked_i` fall appears on `rst_o` after at most SYNC_STAGES+1 edges.
- `rst_req_i` appears on `rst_o` 1 edge after it is sampled high.
- Lock that toggles during HOLD restarts HOLD from zero; there is no partial credit.

## Configuration
- `RST_SEQ_DEBOUNCE_EN` defined:
  - `btn_lvl` rises only after `btn_s` has been high for DEBOUNCE_CYCLES consecutive cycles.
  - `btn_lvl` falls on the first cycle `btn_s` is low.
  - A glitch shorter than DEBOUNCE_CYCLES has no effect.
- `RST_SEQ_DEBOUNCE_EN` undefined: `btn_lvl` = `btn_s`, and the debounce counter is not instantiated.

## Structure
- `rst_seq_pkg` holds the `rst_seq_state_t` enum (WAIT_LOCK, HOLD, RELEASE, RUN) and the default constants (for example `RST_SEQ_DEBOUNCE_1MS_65M` = 65000).
- One sub-module, `debounce`: synchroniser plus stable-level counter, parametrised by SYNC_STAGES and DEBOUNCE_CYCLES. It is instantiated for `btn_i`.
- `top_game_basys3` instantiates `rst_sequencer` with `rst_o[0]` driving `top_vga`.

## Test plan
All scenarios use N_CH=3, HOLD=4, STAGGER=2, SYNC=2.
- Power-up: `rst_n` low, then high; `locked_i` rises → `rst_o` goes 111 → 110 → 100 → 000 at cycles 5/7/9 after `locked_s`; `ready_o`=1 at cycle 10.
- Lock lost in RUN: drop `locked_i` → `rst_o`=111 and `ready_o`=0 within 3 edges; on relock the full sequence repeats with the same spacing.
- Abort mid-RELEASE: `rst_req_i` pulse 1 cycle after `rst_o[0]` clears → 111 next edge, then the sequence restarts and `rst_o[1]` never clears early.
- Lock glitch in HOLD: `locked_i` low 1 cycle at HOLD cnt=2 → release delayed by the full HOLD again.
- Debounce (macro on, DEBOUNCE=10):
  - 9-cycle button pulse → no change on `rst_o`;
  - 12-cycle pulse → 111 from the 11th cycle of synced high, and the sequence restarts after release.
- Async reset mid-RUN: `rst_n` low → `rst_o`=111 and `state_o`=0 immediately, without waiting for a clock edge.
